// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the serial game-pad scanner: FSM states,
// button bit positions inside a committed pad field, and 50 MHz timing defaults.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PULSE_LO,
    PULSE_HI,
    DONE
  } scan_state_t;

  // NES field positions: the first bit shifted out of the pad lands in the MSB
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  // SNES 16-bit field positions; bits 3..0 are unused by the pad and read as released
  localparam int SNES_B      = 15;
  localparam int SNES_Y      = 14;
  localparam int SNES_SELECT = 13;
  localparam int SNES_START  = 12;
  localparam int SNES_UP     = 11;
  localparam int SNES_DOWN   = 10;
  localparam int SNES_LEFT   = 9;
  localparam int SNES_RIGHT  = 8;
  localparam int SNES_A      = 7;
  localparam int SNES_X      = 6;
  localparam int SNES_L      = 5;
  localparam int SNES_R      = 4;

  localparam int DEF_LATCH_CYCLES    = 600;
  localparam int DEF_HALF_BIT_CYCLES = 300;
  localparam int DEF_POLL_CYCLES     = 833334;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_poll_timer.sv
// Free-running wrap counter that emits a one-cycle expiry pulse every
// POLL_CYCLES clocks; POLL_CYCLES == 0 keeps the pulse permanently low.
module nes_poll_timer
  import nes_pad_pkg::*;
#(
  parameter int POLL_CYCLES = DEF_POLL_CYCLES
) (
  input  logic clock,
  input  logic reset,
  output logic expire
);

  localparam bit ENABLED = (POLL_CYCLES != 0);
  localparam int CW      = $clog2(max2(POLL_CYCLES, 2));
  localparam int LAST    = ENABLED ? POLL_CYCLES - 1 : 0;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (count == CW'(LAST)) begin
      count  <= '0;
      expire <= ENABLED;
    end else begin
      count  <= count + 1'b1;
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/nes_pad_scanner.sv
// Multi-pad NES/SNES serial scanner: drives a shared latch/pulse pair, shifts
// every pad into a shadow word and commits it with pressed/released edges.
module nes_pad_scanner
  import nes_pad_pkg::*;
#(
  parameter int NUM_PADS        = 2,
  parameter int NUM_BITS        = 8,
  parameter int LATCH_CYCLES    = DEF_LATCH_CYCLES,
  parameter int HALF_BIT_CYCLES = DEF_HALF_BIT_CYCLES,
  parameter int POLL_CYCLES     = DEF_POLL_CYCLES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PADS-1:0]          data,
  input  logic                         poll_now,
  output logic                         latch,
  output logic                         pulse,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         frame_valid,
  output logic                         busy
);

  localparam int W  = NUM_PADS * NUM_BITS;
  localparam int PW = $clog2(max2(max2(LATCH_CYCLES, HALF_BIT_CYCLES), 2));
  localparam int BW = $clog2(max2(NUM_BITS, 2));

  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);

  scan_state_t   state;
  logic [PW-1:0] phase;
  logic [BW-1:0] bit_idx;
  logic          poll_pending;
  logic          expire;
  logic          start;
  logic          sample;
  logic [W-1:0]  shadow;

  nes_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_poll_timer (
    .clock (clock),
    .reset (reset),
    .expire(expire)
  );

  assign start  = (state == IDLE) && (poll_now || poll_pending);
  // Pads are sampled as pulse falls: end of latch, then end of each high phase
  assign sample = ((state == LATCH)    && (phase == LATCH_LAST)) ||
                  ((state == PULSE_HI) && (phase == HALF_LAST));

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [NUM_BITS-1:0] shift;

    always_ff @(posedge clock) begin
      if (reset) begin
        shift <= '0;
      end else if (sample) begin
        shift <= {shift[NUM_BITS-2:0], ~data[p]};
      end
    end

    assign shadow[p*NUM_BITS +: NUM_BITS] = shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      bit_idx      <= '0;
      poll_pending <= 1'b0;
      latch        <= 1'b0;
      pulse        <= 1'b1;
      busy         <= 1'b0;
      frame_valid  <= 1'b0;
      buttons      <= '0;
      pressed      <= '0;
      released     <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (expire) begin
        poll_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LATCH;
            phase        <= '0;
            bit_idx      <= '0;
            latch        <= 1'b1;
            pulse        <= 1'b1;
            busy         <= 1'b1;
            poll_pending <= expire;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            state <= PULSE_LO;
            phase <= '0;
            latch <= 1'b0;
            pulse <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        PULSE_LO: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            pulse <= 1'b1;
            if (bit_idx == BIT_LAST) begin
              // Commit lands on entry to DONE so outputs are valid during it
              state       <= DONE;
              buttons     <= shadow;
              pressed     <= shadow & ~buttons;
              released    <= ~shadow & buttons;
              frame_valid <= 1'b1;
            end else begin
              state <= PULSE_HI;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        PULSE_HI: begin
          if (phase == HALF_LAST) begin
            state   <= PULSE_LO;
            phase   <= '0;
            pulse   <= 1'b0;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Bench for nes_pad_scanner: behavioural pad devices plus a frame-level model
// of committed buttons and pressed/released edges on 8-bit and 16-bit builds.
module tb_nes_pad_scanner;

  localparam int LATCH_C = 600;
  localparam int HALF_C  = 300;
  localparam int NP      = 2;
  localparam int NB_A    = 8;
  localparam int NB_B    = 16;
  localparam int POLL_B  = 12000;
  localparam int FV_A    = LATCH_C + (2 * NB_A - 1) * HALF_C;
  localparam int FV_B    = LATCH_C + (2 * NB_B - 1) * HALF_C;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic                 reset_a, poll_now_a, latch_a, pulse_a, fv_a, busy_a;
  logic [NP-1:0]        data_a;
  logic [NP*NB_A-1:0]   buttons_a, pressed_a, released_a;
  logic                 reset_b, poll_now_b, latch_b, pulse_b, fv_b, busy_b;
  logic [NP-1:0]        data_b;
  logic [NP*NB_B-1:0]   buttons_b, pressed_b, released_b;

  nes_pad_scanner #(
    .NUM_PADS(NP), .NUM_BITS(NB_A), .LATCH_CYCLES(LATCH_C),
    .HALF_BIT_CYCLES(HALF_C), .POLL_CYCLES(0)
  ) dut_a (
    .clock(clock), .reset(reset_a), .data(data_a), .poll_now(poll_now_a),
    .latch(latch_a), .pulse(pulse_a), .buttons(buttons_a), .pressed(pressed_a),
    .released(released_a), .frame_valid(fv_a), .busy(busy_a)
  );

  nes_pad_scanner #(
    .NUM_PADS(NP), .NUM_BITS(NB_B), .LATCH_CYCLES(LATCH_C),
    .HALF_BIT_CYCLES(HALF_C), .POLL_CYCLES(POLL_B)
  ) dut_b (
    .clock(clock), .reset(reset_b), .data(data_b), .poll_now(poll_now_b),
    .latch(latch_b), .pulse(pulse_b), .buttons(buttons_b), .pressed(pressed_b),
    .released(released_b), .frame_valid(fv_b), .busy(busy_b)
  );

  // Pad devices: latch reloads the button word, each pulse rise shifts out the next bit
  logic [NB_A-1:0] word_a [NP];
  logic [NB_B-1:0] word_b [NP];
  int   idx_a = 0, idx_b = 0;
  logic pp_a = 1'b1, pp_b = 1'b1, pl_a = 1'b0;
  int   falls_a = 0, fvs_a = 0, latches_a = 0;

  always @(negedge clock) begin
    if (pp_a === 1'b1 && pulse_a === 1'b0) falls_a++;
    if (fv_a === 1'b1) fvs_a++;
    if (latch_a === 1'b1 && pl_a !== 1'b1) latches_a++;
    if (latch_a === 1'b1) idx_a = 0;
    else if (pp_a === 1'b0 && pulse_a === 1'b1) idx_a++;
    pp_a = pulse_a;
    pl_a = latch_a;
    for (int p = 0; p < NP; p++)
      data_a[p] = (idx_a < NB_A) ? ~word_a[p][NB_A-1-idx_a] : 1'b1;
  end

  always @(negedge clock) begin
    if (latch_b === 1'b1) idx_b = 0;
    else if (pp_b === 1'b0 && pulse_b === 1'b1) idx_b++;
    pp_b = pulse_b;
    for (int p = 0; p < NP; p++)
      data_b[p] = (idx_b < NB_B) ? ~word_b[p][NB_B-1-idx_b] : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [NP*NB_A-1:0] prev_a = '0;

  task automatic scan_a(input string tag, input logic [NB_A-1:0] w0,
                        input logic [NB_A-1:0] w1, input int poke_at);
    logic [NP*NB_A-1:0] nw;
    int k, f0, v0, l0;
    word_a[0] = w0;
    word_a[1] = w1;
    nw = {w1, w0};
    @(negedge clock);
    #1;
    f0 = falls_a; v0 = fvs_a; l0 = latches_a;
    poll_now_a = 1'b1;
    @(negedge clock);
    poll_now_a = 1'b0;
    check({tag, "_latch0"}, latch_a, 1'b1);
    k = 0;
    while (fv_a !== 1'b1 && k < 6000) begin
      @(negedge clock);
      k++;
      poll_now_a = (k == poke_at);
    end
    poll_now_a = 1'b0;
    check({tag, "_fv_cycle"}, k, FV_A);
    check({tag, "_buttons"}, buttons_a, nw);
    check({tag, "_pressed"}, pressed_a, nw & ~prev_a);
    check({tag, "_released"}, released_a, ~nw & prev_a);
    check({tag, "_busy_done"}, busy_a, 1'b1);
    prev_a = nw;
    @(negedge clock);
    check({tag, "_fv_drop"}, fv_a, 1'b0);
    check({tag, "_busy_drop"}, busy_a, 1'b0);
    repeat (20) @(negedge clock);
    #1;
    check({tag, "_falls"}, falls_a - f0, NB_A);
    check({tag, "_fv_count"}, fvs_a - v0, 1);
    check({tag, "_scan_count"}, latches_a - l0, 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   k, j, v0, l0;
    logic [NP*NB_B-1:0] nb, pb;

    reset_a = 1'b1; reset_b = 1'b1;
    poll_now_a = 1'b0; poll_now_b = 1'b0;
    for (int p = 0; p < NP; p++) begin
      word_a[p] = '0;
      word_b[p] = '0;
    end
    repeat (3) @(negedge clock);
    check("rst_latch", latch_a, 1'b0);
    check("rst_pulse", pulse_a, 1'b1);
    check("rst_buttons", buttons_a, '0);
    check("rst_pressed", pressed_a, '0);
    check("rst_released", released_a, '0);
    check("rst_fv", fv_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);

    reset_a = 1'b0;
    ok = 1'b1;
    repeat (1000) begin
      @(negedge clock);
      if (latch_a !== 1'b0 || pulse_a !== 1'b1 || busy_a !== 1'b0 ||
          buttons_a !== '0 || fv_a !== 1'b0) ok = 1'b0;
    end
    check("idle_quiet", ok, 1'b1);

    scan_a("a_right", 8'h81, 8'h00, -1);
    scan_a("start_only", 8'h11, 8'h00, -1);
    scan_a("rand1", 8'($urandom), 8'($urandom), -1);
    scan_a("rand_poke", 8'($urandom), 8'($urandom), 1000);
    scan_a("rand2", 8'($urandom), 8'($urandom), -1);

    // Reset at cycle 2000 of a scan
    word_a[0] = 8'($urandom);
    word_a[1] = 8'($urandom);
    @(negedge clock);
    #1;
    v0 = fvs_a;
    poll_now_a = 1'b1;
    @(negedge clock);
    poll_now_a = 1'b0;
    repeat (2000) @(negedge clock);
    reset_a = 1'b1;
    @(negedge clock);
    check("midrst_latch", latch_a, 1'b0);
    check("midrst_pulse", pulse_a, 1'b1);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_buttons", buttons_a, '0);
    check("midrst_pressed", pressed_a, '0);
    check("midrst_released", released_a, '0);
    check("midrst_fv", fv_a, 1'b0);
    reset_a = 1'b0;
    #1;
    l0 = latches_a;
    repeat (6000) @(negedge clock);
    #1;
    check("midrst_no_frame", fvs_a - v0, 0);
    check("midrst_no_scan", latches_a - l0, 0);
    prev_a = '0;
    scan_a("after_rst", 8'($urandom), 8'($urandom), -1);
    reset_a = 1'b1;

    // 16-bit build with auto-poll expiring inside a poll_now scan
    check("b_rst_buttons", buttons_b, '0);
    check("b_rst_latch", latch_b, 1'b0);
    word_b[0] = 16'h0000;
    word_b[1] = 16'hFFFF;
    @(negedge clock);
    reset_b = 1'b0;
    repeat (5000) @(negedge clock);
    poll_now_b = 1'b1;
    @(negedge clock);
    poll_now_b = 1'b0;
    check("b_latch0", latch_b, 1'b1);
    k = 0;
    while (fv_b !== 1'b1 && k < 12000) begin
      @(negedge clock);
      k++;
    end
    nb = {word_b[1], word_b[0]};
    check("b_fv_cycle", k, FV_B);
    check("b_buttons", buttons_b, nb);
    check("b_pressed", pressed_b, nb);
    check("b_released", released_b, '0);
    pb = nb;
    word_b[0] = 16'($urandom);
    word_b[1] = 16'($urandom);
    j = 0;
    do begin
      @(negedge clock);
      j++;
    end while (latch_b !== 1'b1 && j < 50);
    check("b_pending_gap", j, 2);
    k = 0;
    while (fv_b !== 1'b1 && k < 12000) begin
      @(negedge clock);
      k++;
    end
    nb = {word_b[1], word_b[0]};
    check("b2_fv_cycle", k, FV_B);
    check("b2_buttons", buttons_b, nb);
    check("b2_pressed", pressed_b, nb & ~pb);
    check("b2_released", released_b, ~nb & pb);
    reset_b = 1'b1;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_scanner.md
# nes_pad_scanner

Parametrised serial game-pad scanner, the next generation of the single-pad NES reader. It drives one shared latch/pulse pair to NUM_PADS shift-register controllers (NES 8-bit or SNES 16-bit) and samples one data line per pad. It publishes debounced-by-frame button words plus per-frame pressed/released event masks and a frame strobe. It sits between the board I/O pins and the processor's memory-mapped peripheral bus.

## Interface
- NUM_PADS, 2: controllers sharing latch/pulse, 1..4
- NUM_BITS, 8: bits shifted per pad (8 = NES, 16 = SNES)
- LATCH_CYCLES, 600: latch high time in clocks (12 us at 50 MHz)
- HALF_BIT_CYCLES, 300: each pulse low/high phase in clocks (6 us)
- POLL_CYCLES, 833334: auto-poll period in clocks (60 Hz); 0 disables auto-poll
- clock  in  1  single system clock; all logic on posedge
- reset  in  1  synchronous, active-high; aborts any scan
- data  in  NUM_PADS  serial data from each pad, active-low (0 = pressed)
- poll_now  in  1  one-cycle request to start a scan immediately
- latch  out  1  registered; high during latch phase
- pulse  out  1  registered; clock to pads, idles high
- buttons  out  NUM_PADS*NUM_BITS  committed active-high button state, pad p at [p*NUM_BITS +: NUM_BITS]
- pressed  out  NUM_PADS*NUM_BITS  bits that went 0->1 in the last committed frame
- released  out  NUM_PADS*NUM_BITS  bits that went 1->0 in the last committed frame
- frame_valid  out  1  one-cycle strobe when buttons/pressed/released update
- busy  out  1  high from scan start through the DONE cycle

## Operation
- FSM states: IDLE, LATCH, PULSE_LO, PULSE_HI, DONE. A single phase counter (width clog2 of max(LATCH_CYCLES, HALF_BIT_CYCLES)) and a bit index (clog2 NUM_BITS) are used.
- IDLE: latch=0, pulse=1. The FSM leaves IDLE on poll_now or a pending auto-poll, whichever arrives first. Both are cleared on entry to LATCH.
- LATCH: latch=1, pulse=1 for LATCH_CYCLES. On exit, every pad samples bit 0 (~data). Transition to PULSE_LO.
- PULSE_LO: latch=0, pulse=0 for HALF_BIT_CYCLES. At the end, go to DONE if bit index == NUM_BITS-1, else go to PULSE_HI.
- PULSE_HI: pulse=1 for HALF_BIT_CYCLES. On exit, increment bit index, sample that bit into the shadow register, and go to PULSE_LO.
- Shadow ordering: first bit shifted lands in the field MSB (NES: A=7, B=6, Select=5, Start=4, Up=3, Down=2, Left=1, Right=0).
- DONE (1 cycle):
  - buttons <= shadow
  - pressed <= shadow & ~buttons
  - released <= ~shadow & buttons
  - frame_valid=1
  - next state IDLE
- pressed/released hold until the next DONE.
- Auto-poll timer is free-running from reset and wraps at POLL_CYCLES-1. Expiry sets the pending flag. Expiry while busy stays pending, so a scan starts the cycle after DONE returns to IDLE.
- poll_now while busy is ignored (not queued).
- reset mid-scan: all outputs go to reset values next cycle and the shadow is cleared. No frame_valid is emitted.

## Timing
- Reset values: latch=0, pulse=1, buttons=0, pressed=0, released=0, frame_valid=0, busy=0, timer=0, FSM=IDLE.
- Scan start (cycle 0) = first cycle latch=1, one cycle after the trigger is seen in IDLE.
- Bit k is sampled at the edge ending cycle LATCH_CYCLES + 2*k*HALF_BIT_CYCLES - 1. With defaults: 600, 1200, … 4800 after start, coincident with pulse falling.
- frame_valid is asserted at cycle LATCH_CYCLES + (2*NUM_BITS-1)*HALF_BIT_CYCLES (default 5100). buttons updates the same edge.
- Scan length must be < POLL_CYCLES; otherwise at most one poll stays pending.
- All outputs are registered; data has no extra synchroniser (pads are slow, sampled mid-phase).

## Structure
- Package nes_pad_pkg holds:
  - FSM state enum
  - NES button index constants (BTN_A..BTN_RIGHT)
  - SNES 16-bit index constants
  - default timing localparams for 50 MHz
- Sub-module nes_poll_timer provides a parametrised wrap counter with expiry pulse and POLL_CYCLES==0 disable.
- Per-pad shadow shift registers are generated with a generate loop inside nes_pad_scanner.

## Test plan
- Reset, no triggers, POLL_CYCLES=0 -> latch=0, pulse=1, buttons=0, busy=0 indefinitely.
- poll_now, pad0 model returns A+Right pressed (data low at bits 7,0) -> buttons[7:0]=8'h81, pressed=8'h81, frame_valid exactly at cycle 5100, 8 pulse falling edges.
- Next frame with pad0 A released, Start pressed -> buttons[7:0]=8'h11, pressed=8'h10, released=8'h80.
- NUM_PADS=2, NUM_BITS=16, pad1 all pressed -> buttons[31:16]=16'hFFFF, pad0 field 0, frame_valid at 600+31*300=9900.
- Timer expiry during a poll_now scan -> second scan starts exactly 2 cycles after frame_valid; poll_now mid-scan produces no extra scan.
- reset asserted at cycle 2000 of a scan -> outputs at reset values next cycle, no frame_valid, next scan fully correct.
